// File: rtl/rng_arbiter.sv
// rng_arbiter: power/warm-up controller, repetition-count health test and
// two-port round-robin arbiter for the 128-bit ring-oscillator RNG datapath.
module rng_arbiter #(
    parameter int unsigned WARMUP_CYCLES = 64,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned REP_LIMIT     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] rng_data,
    output logic         rng_enable,
    input  logic [1:0]   req,
    output logic [1:0]   ack,
    output logic [127:0] rand_data,
    output logic         busy,
    output logic         health_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_SAMPLE,
        S_GRANT,
        S_GAP,
        S_FAIL
    } state_t;

    localparam logic [15:0] WARM_LAST = 16'(WARMUP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [7:0]  REP_LIM   = 8'(REP_LIMIT);

    state_t         state_q, state_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [127:0]   smp_q, smp_d;
    logic [127:0]   prev_q, prev_d;
    logic           prev_valid_q, prev_valid_d;
    logic [7:0]     rep_cnt_q, rep_cnt_d;
    logic           last_q, last_d;
    logic           en_q, en_d;
    logic [1:0]     ack_q, ack_d;
    logic [127:0]   rd_q, rd_d;
    logic           busy_q, busy_d;
    logic           hf_q, hf_d;

    logic [7:0]     rep_inc;
    logic           active;
    logic           win;

    assign rep_inc = rep_cnt_q + 8'd1;

    // Outputs are pure register copies; they reflect the state one cycle late.
    assign rng_enable  = en_q;
    assign ack         = ack_q;
    assign rand_data   = rd_q;
    assign busy        = busy_q;
    assign health_fail = hf_q;

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        smp_d        = smp_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        rep_cnt_d    = rep_cnt_q;
        last_d       = last_q;
        ack_d        = 2'b00;
        rd_d         = rd_q;
        hf_d         = hf_q;
        win          = 1'b0;

        // The generator is powered exactly while a word is being produced.
        active = (state_q == S_WARMUP) || (state_q == S_SAMPLE) ||
                 (state_q == S_GRANT)  || (state_q == S_GAP);
        en_d   = active;
        busy_d = active;

        case (state_q)
            S_IDLE: begin
                if (req != 2'b00) begin
                    state_d = S_WARMUP;
                    cnt_d   = 16'd0;
                end
            end
            S_WARMUP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == WARM_LAST) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                smp_d = rng_data;
                if (prev_valid_q && (rng_data == prev_q)) begin
                    rep_cnt_d = rep_inc;
                    if (rep_inc == REP_LIM) begin
                        state_d = S_FAIL;
                    end else begin
                        // Repeated word is withheld but still counts toward the limit.
                        state_d      = S_GAP;
                        cnt_d        = 16'd0;
                        prev_d       = rng_data;
                        prev_valid_d = 1'b1;
                    end
                end else begin
                    rep_cnt_d    = 8'd1;
                    state_d      = S_GRANT;
                    prev_d       = rng_data;
                    prev_valid_d = 1'b1;
                end
            end
            S_GRANT: begin
                if (req == 2'b00) begin
                    state_d = S_IDLE;
                end else begin
                    // With both requesting, the one not served last time wins.
                    win     = (req == 2'b11) ? ~last_q : req[1];
                    ack_d   = win ? 2'b10 : 2'b01;
                    rd_d    = smp_q;
                    last_d  = win;
                    state_d = S_GAP;
                    cnt_d   = 16'd0;
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == GAP_LAST) begin
                    state_d = (req != 2'b00) ? S_SAMPLE : S_IDLE;
                end
            end
            S_FAIL: begin
                hf_d = 1'b1;
                rd_d = 128'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and output registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 16'd0;
            prev_valid_q <= 1'b0;
            rep_cnt_q    <= 8'd0;
            last_q       <= 1'b1;
            en_q         <= 1'b0;
            ack_q        <= 2'b00;
            rd_q         <= 128'd0;
            busy_q       <= 1'b0;
            hf_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_valid_q <= prev_valid_d;
            rep_cnt_q    <= rep_cnt_d;
            last_q       <= last_d;
            en_q         <= en_d;
            ack_q        <= ack_d;
            rd_q         <= rd_d;
            busy_q       <= busy_d;
            hf_q         <= hf_d;
        end
    end

    // Sample storage; qualified by prev_valid_q and the FSM, so no reset needed.
    always_ff @(posedge clk) begin
        smp_q  <= smp_d;
        prev_q <= prev_d;
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// Self-checking bench for rng_arbiter: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_rng_arbiter;

    localparam int W = 4;
    localparam int G = 2;
    localparam int R = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] rng_data;
    logic         rng_enable;
    logic [1:0]   req;
    logic [1:0]   ack;
    logic [127:0] rand_data;
    logic         busy;
    logic         health_fail;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    rng_arbiter #(
        .WARMUP_CYCLES(W),
        .GAP_CYCLES   (G),
        .REP_LIMIT    (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rng_data   (rng_data),
        .rng_enable (rng_enable),
        .req        (req),
        .ack        (ack),
        .rand_data  (rand_data),
        .busy       (busy),
        .health_fail(health_fail)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: phases with a countdown of remaining cycles, a
    // repetition streak over delivered/withheld samples, and a round-robin
    // pointer. Predicted outputs are those visible just after the edge.
    localparam int P_IDLE = 0, P_WARM = 1, P_SAMP = 2, P_GRANT = 3, P_GAP = 4, P_FAIL = 5;
    int           mph = P_IDLE;
    int           mleft = 0;
    int           mstreak = 0;
    int           mptr = 1;
    bit           mhave = 0;
    logic [127:0] mlast = '0;
    logic [127:0] mword = '0;
    logic         m_en = 0, m_busy = 0, m_hf = 0;
    logic [1:0]   m_ack = 0;
    logic [127:0] m_rd = '0;

    task automatic model(input logic r, input logic [1:0] q, input logic [127:0] d);
        int w;
        if (r) begin
            mph = P_IDLE; mstreak = 0; mhave = 0; mptr = 1;
            m_en = 0; m_busy = 0; m_hf = 0; m_ack = 0; m_rd = '0;
            return;
        end
        m_en   = (mph != P_IDLE) && (mph != P_FAIL);
        m_busy = m_en;
        m_ack  = 2'b00;
        case (mph)
            P_IDLE: if (q != 2'b00) begin mph = P_WARM; mleft = W; end
            P_WARM: begin mleft--; if (mleft == 0) mph = P_SAMP; end
            P_SAMP: begin
                mword = d;
                if (mhave && d == mlast) begin
                    mstreak++;
                    if (mstreak == R) mph = P_FAIL;
                    else begin mph = P_GAP; mleft = G; end
                end else begin
                    mstreak = 1;
                    mph = P_GRANT;
                end
                mlast = d;
                mhave = 1;
            end
            P_GRANT: begin
                if (q == 2'b00) mph = P_IDLE;
                else begin
                    w = (q == 2'b11) ? 1 - mptr : (q[1] ? 1 : 0);
                    m_ack = (w == 1) ? 2'b10 : 2'b01;
                    m_rd  = mword;
                    mptr  = w;
                    mph   = P_GAP;
                    mleft = G;
                end
            end
            P_GAP: begin mleft--; if (mleft == 0) mph = (q != 2'b00) ? P_SAMP : P_IDLE; end
            default: begin m_hf = 1; m_rd = '0; end
        endcase
    endtask

    // One clock: drive inputs, advance the model on the edge, compare after it.
    task automatic step(input logic r, input logic [1:0] q, input logic [127:0] d);
        rst = r; req = q; rng_data = d;
        @(posedge clk);
        cyc++;
        model(r, q, d);
        #1;
        check("model_ack", {126'd0, ack}, {126'd0, m_ack});
        check("model_enable", {127'd0, rng_enable}, {127'd0, m_en});
        check("model_busy", {127'd0, busy}, {127'd0, m_busy});
        check("model_health_fail", {127'd0, health_fail}, {127'd0, m_hf});
        check("model_rand_data", rand_data, m_rd);
    endtask

    // Reset for one cycle; the next step is numbered cycle 0.
    task automatic do_reset();
        step(1'b1, 2'b00, '0);
        check("reset_outputs", {rand_data, ack, rng_enable, busy, health_fail}, '0);
        cyc = -1;
    endtask

    typedef struct {
        logic [1:0]   req;
        logic         en;
        logic         busy;
        logic [1:0]   ack;
        logic         chk_rd;
        logic [127:0] rd;
    } vec_t;

    vec_t t1[$];
    vec_t t5[$];

    function automatic vec_t mk(input logic [1:0] q, input logic e, input logic b,
                                input logic [1:0] a, input logic c, input logic [127:0] rd);
        vec_t v;
        v.req = q; v.en = e; v.busy = b; v.ack = a; v.chk_rd = c; v.rd = rd;
        return v;
    endfunction

    task automatic run_table(input string tag, input vec_t tab[$]);
        for (int i = 0; i < tab.size(); i++) begin
            step(1'b0, tab[i].req, 128'(i));
            check({tag, "_enable"}, {127'd0, rng_enable}, {127'd0, tab[i].en});
            check({tag, "_busy"}, {127'd0, busy}, {127'd0, tab[i].busy});
            check({tag, "_ack"}, {126'd0, ack}, {126'd0, tab[i].ack});
            if (tab[i].chk_rd) check({tag, "_rand_data"}, rand_data, tab[i].rd);
        end
    endtask

    initial begin
        logic [127:0] A, B, S, lastd;
        logic [1:0]   q;
        logic         r;
        int           late_acks;

        A = {4{32'h1111_2222}};
        B = {4{32'h3333_4444}};
        S = {16{8'hA5}};

        // Scenario 1: single requester, word taken then request dropped.
        t1.push_back(mk(2'b01, 0, 0, 2'b00, 0, '0));
        for (int i = 1; i <= 5; i++) t1.push_back(mk(2'b01, 1, 1, 2'b00, 0, '0));
        t1.push_back(mk(2'b01, 1, 1, 2'b01, 1, 128'd5));
        t1.push_back(mk(2'b00, 1, 1, 2'b00, 1, 128'd5));
        t1.push_back(mk(2'b00, 1, 1, 2'b00, 1, 128'd5));
        t1.push_back(mk(2'b00, 0, 0, 2'b00, 1, 128'd5));

        // Scenario 5: one-cycle request pulse, sample thrown away in GRANT.
        t5.push_back(mk(2'b01, 0, 0, 2'b00, 0, '0));
        for (int i = 1; i <= 5; i++) t5.push_back(mk(2'b00, 1, 1, 2'b00, 0, '0));
        t5.push_back(mk(2'b00, 1, 1, 2'b00, 1, '0));
        t5.push_back(mk(2'b00, 0, 0, 2'b00, 1, '0));

        do_reset();
        run_table("t1", t1);
        do_reset();
        run_table("t5", t5);

        // Scenario 2: both requesting, alternating grants every G+2 cycles.
        do_reset();
        for (int e = 0; e <= 18; e++) begin
            step(1'b0, 2'b11, 128'(e + 100));
            if (e >= 1) check("t2_busy", {127'd0, busy}, 128'd1);
            if (e == 6 || e == 14) check("t2_ack_port0", {126'd0, ack}, 128'd1);
            if (e == 10 || e == 18) check("t2_ack_port1", {126'd0, ack}, 128'd2);
        end

        // Scenario 4: A, A, B -- repeated A withheld, B delivered.
        do_reset();
        for (int e = 0; e <= 14; e++) begin
            step(1'b0, 2'b01, (e <= 9) ? A : B);
            if (e == 6) begin
                check("t4_ack_first", {126'd0, ack}, 128'd1);
                check("t4_word_A", rand_data, A);
            end
            if (e == 10) check("t4_no_ack_repeat", {126'd0, ack}, 128'd0);
            if (e == 13) begin
                check("t4_ack_B", {126'd0, ack}, 128'd1);
                check("t4_word_B", rand_data, B);
            end
        end
        check("t4_health_ok", {127'd0, health_fail}, 128'd0);

        // Scenario 3: stuck data trips the health test on the third sample.
        do_reset();
        late_acks = 0;
        for (int e = 0; e <= 20; e++) begin
            step(1'b0, 2'b01, S);
            if (e == 6) check("t3_first_word", rand_data, S);
            if (e >= 7 && ack != 2'b00) late_acks++;
            if (e == 13) begin
                check("t3_health_fail", {127'd0, health_fail}, 128'd1);
                check("t3_enable_off", {127'd0, rng_enable}, 128'd0);
                check("t3_rand_cleared", rand_data, 128'd0);
            end
        end
        check("t3_no_late_ack", 128'(late_acks), 128'd0);

        // Scenario 6b: reset out of FAIL; stuck value accepted again as first sample.
        do_reset();
        for (int e = 0; e <= 6; e++) begin
            step(1'b0, 2'b01, S);
            if (e == 6) begin
                check("t6_after_fail_ack", {126'd0, ack}, 128'd1);
                check("t6_after_fail_word", rand_data, S);
            end
        end

        // Scenario 6a: reset during WARMUP, then full-latency restart.
        do_reset();
        for (int e = 0; e <= 2; e++) step(1'b0, 2'b01, 128'(e));
        step(1'b1, 2'b01, '0);
        check("t6_mid_reset_enable", {127'd0, rng_enable}, 128'd0);
        check("t6_mid_reset_busy", {127'd0, busy}, 128'd0);
        cyc = -1;
        for (int e = 0; e <= 6; e++) begin
            step(1'b0, 2'b01, 128'(e + 50));
            if (e == 5) check("t6_no_early_ack", {126'd0, ack}, 128'd0);
            if (e == 6) check("t6_restart_ack", {126'd0, ack}, 128'd1);
        end

        // Randomized traffic against the model.
        do_reset();
        q = 2'b01;
        lastd = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) q = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 299) == 0) || (health_fail && $urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) != 0) lastd = {$urandom, $urandom, $urandom, $urandom};
            step(r, q, lastd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
